// File: rtl/cardrom_loader.sv
// Copies an IMAGE_BYTES image from a byte stream into the shared card ROM RAM, yielding to Apple II bus reads.
// Optional image checksum check is compiled in with `define CARDROM_CHECKSUM_EN.
module cardrom_loader #(
    parameter int IMAGE_BYTES    = 2048,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk_logic,
    input  logic        system_reset_n,
    input  logic        start_i,
    input  logic        src_valid_i,
    input  logic [7:0]  src_data_i,
    output logic        src_ready_o,
    input  logic        bus_rd_i,
    input  logic [10:0] bus_addr_i,
    output logic [10:0] ram_addr_o,
    output logic        ram_we_o,
    output logic [7:0]  ram_wdata_o,
    input  logic [15:0] expected_sum_i,
    output logic        req_rom_release_o,
    output logic        busy_o,
    output logic        error_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [10:0]   LAST_BYTE = 11'(IMAGE_BYTES - 1);
    localparam logic [TW-1:0] LAST_IDLE = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, VERIFY, DONE, ERROR} state_t;

    state_t        state, state_nxt;
    logic [10:0]   byte_cnt, byte_cnt_nxt;
    logic [TW-1:0] idle_cnt, idle_cnt_nxt;
    logic          accept;
    logic          load_start;
    logic          verify_ok;

    // Bus reads own the RAM port; the loader only gets it when the bus is quiet.
    always_comb begin
        src_ready_o       = (state == LOAD) && !bus_rd_i;
        accept            = src_ready_o && src_valid_i;
        load_start        = start_i && ((state == IDLE) || (state == ERROR));
        ram_we_o          = accept;
        ram_addr_o        = accept ? byte_cnt : bus_addr_i;
        ram_wdata_o       = accept ? src_data_i : '0;
        busy_o            = (state == LOAD) || (state == VERIFY);
        error_o           = (state == ERROR);
        req_rom_release_o = (state == DONE);
    end

`ifdef CARDROM_CHECKSUM_EN
    logic [15:0] sum;

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            sum <= '0;
        end else if (load_start) begin
            sum <= '0;
        end else if (accept) begin
            sum <= sum + {8'h00, src_data_i};
        end
    end

    assign verify_ok = (sum == expected_sum_i);
`else
    logic unused_expected_sum;

    assign unused_expected_sum = ^expected_sum_i;
    assign verify_ok           = 1'b1;
`endif

    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        idle_cnt_nxt = idle_cnt;
        case (state)
            IDLE, ERROR: begin
                if (load_start) begin
                    state_nxt    = LOAD;
                    byte_cnt_nxt = '0;
                    idle_cnt_nxt = '0;
                end
            end
            LOAD: begin
                if (accept) begin
                    byte_cnt_nxt = byte_cnt + 11'd1;
                    idle_cnt_nxt = '0;
                    if (byte_cnt == LAST_BYTE) begin
                        state_nxt = VERIFY;
                    end
                end else if (idle_cnt == LAST_IDLE) begin
                    state_nxt = ERROR;
                end else begin
                    idle_cnt_nxt = idle_cnt + 1'b1;
                end
            end
            VERIFY: begin
                state_nxt = verify_ok ? DONE : ERROR;
            end
            default: begin
                state_nxt = state;
            end
        endcase
    end

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state    <= IDLE;
            byte_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
            idle_cnt <= idle_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_cardrom_loader.sv
// Self-checking bench for cardrom_loader (IMAGE_BYTES=16, TIMEOUT_CYCLES=8) against a flag/counter reference model.
module tb_cardrom_loader;

    localparam int IB = 16;
    localparam int TO = 8;
`ifdef CARDROM_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk_logic      = 1'b0;
    logic        system_reset_n = 1'b0;
    logic        start_i        = 1'b0;
    logic        src_valid_i    = 1'b0;
    logic [7:0]  src_data_i     = '0;
    logic        src_ready_o;
    logic        bus_rd_i       = 1'b0;
    logic [10:0] bus_addr_i     = '0;
    logic [10:0] ram_addr_o;
    logic        ram_we_o;
    logic [7:0]  ram_wdata_o;
    logic [15:0] expected_sum_i = '0;
    logic        req_rom_release_o;
    logic        busy_o;
    logic        error_o;

    always #5 clk_logic = ~clk_logic;

    cardrom_loader #(
        .IMAGE_BYTES    (IB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_logic         (clk_logic),
        .system_reset_n    (system_reset_n),
        .start_i           (start_i),
        .src_valid_i       (src_valid_i),
        .src_data_i        (src_data_i),
        .src_ready_o       (src_ready_o),
        .bus_rd_i          (bus_rd_i),
        .bus_addr_i        (bus_addr_i),
        .ram_addr_o        (ram_addr_o),
        .ram_we_o          (ram_we_o),
        .ram_wdata_o       (ram_wdata_o),
        .expected_sum_i    (expected_sum_i),
        .req_rom_release_o (req_rom_release_o),
        .busy_o            (busy_o),
        .error_o           (error_o)
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: what the loader is doing, in plain flags and counts.
    bit          m_load, m_verify, m_done, m_err;
    int          m_count, m_idle;
    logic [15:0] m_sum;
    logic [7:0]  img [IB];
    logic [7:0]  dut_mem [IB];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_load = 0; m_verify = 0; m_done = 0; m_err = 0;
        m_count = 0; m_idle = 0; m_sum = '0;
    endtask

    task automatic clear_mem();
        for (int k = 0; k < IB; k++) dut_mem[k] = 'x;
    endtask

    task automatic chk_mem();
        for (int k = 0; k < IB; k++) chk($sformatf("mem[%0d]", k), 16'(dut_mem[k]), 16'(img[k]));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},   16'(src_ready_o),       16'(0));
        chk({tag, "_we"},      16'(ram_we_o),          16'(0));
        chk({tag, "_addr"},    16'(ram_addr_o),        16'(bus_addr_i));
        chk({tag, "_wdata"},   16'(ram_wdata_o),       16'(0));
        chk({tag, "_release"}, 16'(req_rom_release_o), 16'(0));
        chk({tag, "_busy"},    16'(busy_o),            16'(0));
        chk({tag, "_error"},   16'(error_o),           16'(0));
    endtask

    // One clock cycle: drive, check at negedge, advance model, cross posedge.
    task automatic cyc(input bit st, input bit v, input logic [7:0] d, input bit rd, input logic [10:0] a);
        bit ex_rdy, ex_we;
        start_i = st; src_valid_i = v; src_data_i = d; bus_rd_i = rd; bus_addr_i = a;
        @(negedge clk_logic);
        ex_rdy = m_load && !rd;
        ex_we  = ex_rdy && v;
        chk("src_ready", 16'(src_ready_o), 16'(ex_rdy));
        chk("ram_we",    16'(ram_we_o),    16'(ex_we));
        chk("ram_addr",  16'(ram_addr_o),  ex_we ? 16'(m_count) : 16'(a));
        chk("ram_wdata", 16'(ram_wdata_o), ex_we ? 16'(d) : 16'(0));
        chk("busy",      16'(busy_o),      16'(m_load || m_verify));
        chk("error",     16'(error_o),     16'(m_err));
        chk("release",   16'(req_rom_release_o), 16'(m_done));
        if (ram_we_o === 1'b1 && ram_addr_o < 11'(IB)) dut_mem[ram_addr_o[3:0]] = ram_wdata_o;
        if (m_load) begin
            if (ex_we) begin
                m_sum += 16'(d);
                m_count++;
                m_idle = 0;
                if (m_count == IB) begin m_load = 0; m_verify = 1; end
            end else begin
                m_idle++;
                if (m_idle == TO) begin m_load = 0; m_err = 1; end
            end
        end else if (m_verify) begin
            m_verify = 0;
            if (!CSUM || m_sum == expected_sum_i) m_done = 1; else m_err = 1;
        end else if (st && !m_done) begin
            m_load = 1; m_err = 0; m_count = 0; m_idle = 0; m_sum = '0;
        end
        @(posedge clk_logic);
        #1;
        start_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 8'($urandom), $urandom_range(3) == 0, 11'($urandom));
    endtask

    task automatic feed(input int gap_pct, input int rd_pct, input int budget);
        int n = 0;
        while ((m_load || m_verify) && n < budget) begin
            cyc(0, $urandom_range(99) >= gap_pct, img[m_count % IB],
                $urandom_range(99) < rd_pct, 11'($urandom));
            n++;
        end
        chk("load_within_budget", 16'(m_load || m_verify), 16'(0));
    endtask

    task automatic set_image(input bit ramp);
        logic [15:0] s = '0;
        for (int k = 0; k < IB; k++) begin
            img[k] = ramp ? 8'(k) : 8'($urandom);
            s += 16'(img[k]);
        end
        expected_sum_i = s;
    endtask

    task automatic hit_reset();
        system_reset_n = 1'b0;
        start_i = 1'b0; src_valid_i = 1'b1; bus_rd_i = 1'b0; bus_addr_i = 11'($urandom);
        #1;
        chk_reset_outputs("async_reset");
        model_clear();
        @(posedge clk_logic);
        #1;
        chk_reset_outputs("held_reset");
        system_reset_n = 1'b1;
        src_valid_i = 1'b0;
    endtask

    initial begin
        model_clear();
        clear_mem();
        bus_addr_i = 11'h5A3;
        #1;
        chk_reset_outputs("power_on_reset");
        @(posedge clk_logic);
        #1;
        system_reset_n = 1'b1;
        idle(3);

        // Back-to-back ramp image, correct checksum.
        set_image(1);
        chk("ramp_sum_constant", expected_sum_i, 16'h0078);
        cyc(1, 0, 8'h00, 0, 11'h000);
        feed(0, 0, 60);
        idle(2);
        chk_mem();
        chk("done_release", 16'(req_rom_release_o), 16'(1));

        // start_i in DONE is ignored.
        cyc(1, 1, 8'hAA, 0, 11'h123);
        idle(2);

        // Random image with bus contention, 3-cycle bus read burst and a stray start mid-load.
        hit_reset();
        clear_mem();
        set_image(0);
        cyc(1, 0, 8'h00, 0, 11'h000);
        for (int k = 0; k < 4; k++) cyc(0, 1, img[m_count], 0, 11'($urandom));
        for (int k = 0; k < 3; k++) cyc(0, 1, img[m_count], 1, 11'h7FC);
        cyc(1, 1, img[m_count], 0, 11'($urandom));
        feed(20, 15, 200);
        idle(2);
        chk_mem();

        // Wrong checksum, then retry with the right one.
        hit_reset();
        clear_mem();
        set_image(1);
        expected_sum_i = 16'h0079;
        cyc(1, 0, 8'h00, 0, 11'h000);
        feed(0, 0, 60);
        idle(2);
        chk("bad_sum_error", 16'(error_o), 16'(CSUM));
        expected_sum_i = 16'h0078;
        cyc(1, 0, 8'h00, 0, 11'h000);
        feed(0, 0, 60);
        idle(2);

        // Source stalls after 3 bytes -> timeout; restart loads from address 0.
        hit_reset();
        clear_mem();
        set_image(0);
        cyc(1, 0, 8'h00, 0, 11'h000);
        for (int k = 0; k < 3; k++) cyc(0, 1, img[m_count], 0, 11'($urandom));
        idle(12);
        chk("timeout_error", 16'(error_o), 16'(1));
        clear_mem();
        cyc(1, 0, 8'h00, 0, 11'h000);
        feed(0, 0, 60);
        idle(2);
        chk_mem();

        // Reset after 5 bytes, then a full clean load.
        hit_reset();
        set_image(0);
        cyc(1, 0, 8'h00, 0, 11'h000);
        for (int k = 0; k < 5; k++) cyc(0, 1, img[m_count], 0, 11'($urandom));
        hit_reset();
        idle(2);
        clear_mem();
        cyc(1, 0, 8'h00, 0, 11'h000);
        feed(10, 10, 200);
        idle(2);
        chk_mem();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cardrom_loader.md
CARDROM_LOADER -- requirements
Module: cardrom_loader

Interface
REQ-001 SHALL have parameter IMAGE_BYTES, default 2048, number of bytes copied into the card ROM RAM (power of two, 16..2048).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1048576, maximum idle clk_logic cycles between accepted source bytes before abort.
REQ-003 SHALL have port clk_logic  input  1  single clock for all logic.
REQ-004 SHALL have port system_reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start_i  input  1  load request, one-cycle pulse.
REQ-006 SHALL have port src_valid_i  input  1  source byte valid.
REQ-007 SHALL have port src_data_i  input  8  source byte.
REQ-008 SHALL have port src_ready_o  output  1  loader accepts byte this cycle.
REQ-009 SHALL have port bus_rd_i  input  1  Apple II bus read of the ROM RAM this cycle.
REQ-010 SHALL have port bus_addr_i  input  11  Apple II bus ROM offset.
REQ-011 SHALL have port ram_addr_o  output  11  shared single-port ROM RAM address.
REQ-012 SHALL have port ram_we_o  output  1  ROM RAM write enable.
REQ-013 SHALL have port ram_wdata_o  output  8  ROM RAM write data.
REQ-014 SHALL have port expected_sum_i  input  16  expected image checksum (used only with CARDROM_CHECKSUM_EN).
REQ-015 SHALL have port req_rom_release_o  output  1  level request to the card ROM to release INH.
REQ-016 SHALL have port busy_o  output  1  load in progress.
REQ-017 SHALL have port error_o  output  1  load failed (timeout or checksum).

Function
REQ-018 SHALL implement states IDLE, LOAD, VERIFY, DONE, ERROR.
REQ-019 SHALL move IDLE->LOAD on start_i, clearing byte counter, checksum and timeout counter; start_i in any other state SHALL be ignored.
REQ-020 SHALL, in LOAD, assert src_ready_o only when bus_rd_i is low (bus has priority; src_ready_o combinational from bus_rd_i and state).
REQ-021 SHALL accept a byte when src_valid_i & src_ready_o, driving ram_we_o=1, ram_addr_o=byte counter, ram_wdata_o=src_data_i in that same cycle.
REQ-022 SHALL drive ram_addr_o=bus_addr_i and ram_we_o=0 whenever bus_rd_i is high, in every state.
REQ-023 SHALL increment the byte counter per accepted byte; on acceptance of byte IMAGE_BYTES-1 go to VERIFY next cycle.
REQ-024 SHALL count cycles in LOAD without an accepted byte; reaching TIMEOUT_CYCLES SHALL go to ERROR; an accepted byte SHALL clear the count.
REQ-025 SHALL take exactly one cycle in VERIFY, then go to DONE or ERROR per REQ-034/REQ-035.
REQ-026 SHALL hold req_rom_release_o high in DONE and low in all other states (rising edge consumed by the card ROM).
REQ-027 SHALL assert busy_o in LOAD and VERIFY; error_o in ERROR only.
REQ-028 SHALL leave DONE and ERROR only via reset; ERROR SHALL also accept start_i to retry (ERROR->LOAD, error_o cleared).
REQ-029 SHALL never write the RAM outside LOAD.

Reset
REQ-030 SHALL on system_reset_n low asynchronously enter IDLE with counters, checksum cleared.
REQ-031 SHALL reset outputs: src_ready_o=0, ram_we_o=0, ram_addr_o=bus_addr_i, ram_wdata_o=0, req_rom_release_o=0, busy_o=0, error_o=0.
REQ-032 SHALL on reset mid-LOAD abandon the load with no further RAM writes; a new start_i restarts from byte 0.

Configuration
REQ-033 SHALL compile the checksum feature only when macro CARDROM_CHECKSUM_EN is defined.
REQ-034 With CARDROM_CHECKSUM_EN: SHALL accumulate 16-bit modulo-65536 sum of accepted bytes; VERIFY->DONE if sum==expected_sum_i, else ERROR.
REQ-035 Without CARDROM_CHECKSUM_EN: VERIFY SHALL always go to DONE; expected_sum_i unused; no accumulator logic.

Verification
REQ-036 IMAGE_BYTES=16, start_i, 16 bytes 0x00..0x0F back-to-back -> 16 writes addr 0..15, busy_o low and req_rom_release_o high 2 cycles after last byte.
REQ-037 bus_rd_i high for 3 cycles mid-load with bus_addr_i=0x7FC -> src_ready_o=0, ram_we_o=0, ram_addr_o=0x7FC those cycles; no byte lost or duplicated.
REQ-038 CARDROM_CHECKSUM_EN, bytes 0x00..0x0F, expected_sum_i=0x0078 -> DONE; expected_sum_i=0x0079 -> error_o=1, req_rom_release_o=0.
REQ-039 TIMEOUT_CYCLES=8, src_valid_i held low after 3 bytes -> error_o=1 after 8 idle cycles; start_i then restarts at address 0.
REQ-040 system_reset_n low after 5 bytes -> all outputs at reset values immediately; start_i plus 16 bytes -> normal DONE.
REQ-041 start_i pulsed during LOAD and during DONE -> no state change, counters unaffected.
